// File: rtl/aes_round_ctrl_if.sv
// aes_round_ctrl_if: bus between the AES round controller and its memory, round datapath, key schedule and display.
interface aes_round_ctrl_if;
    logic         START;
    logic [3:0]   MEM_SEL;
    logic [127:0] KEY;
    logic [3:0]   MEM_ADDR;
    logic [127:0] MEM_DATA;
    logic [127:0] RND_STATE;
    logic [127:0] RND_KEY;
    logic         RND_FINAL;
    logic [127:0] RND_RESULT;
    logic [31:0]  KS_WORD;
    logic [3:0]   KS_ROUND;
    logic [31:0]  KS_G;
    logic [1:0]   OUT_SEL;
    logic         BUSY;
    logic         DONE;
    logic [127:0] CT;
    logic [31:0]  HEX;
    modport master (
        output START, MEM_SEL, KEY, MEM_DATA, RND_RESULT, KS_G, OUT_SEL,
        input  MEM_ADDR, RND_STATE, RND_KEY, RND_FINAL, KS_WORD, KS_ROUND, BUSY, DONE, CT, HEX
    );
    modport slave (
        input  START, MEM_SEL, KEY, MEM_DATA, RND_RESULT, KS_G, OUT_SEL,
        output MEM_ADDR, RND_STATE, RND_KEY, RND_FINAL, KS_WORD, KS_ROUND, BUSY, DONE, CT, HEX
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: AES-128 encryption sequencer driving a shared round datapath and key schedule.
// Define AES_ROUND_CTRL_START_QUEUE_EN to queue one START arriving while busy or in DONE.
module aes_round_ctrl (
    input logic CLK,
    input logic RST,
    aes_round_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} state_t;
    state_t st, st_nxt;
    logic [127:0] state_reg, key_reg, ct;
    logic [3:0] round, mem_addr, load_addr;
    logic [31:0] hex, w0, w1, w2, w3;
`ifdef AES_ROUND_CTRL_START_QUEUE_EN
    logic pend;
    logic [3:0] pend_addr;
`endif
    assign w0 = key_reg[127:96] ^ bus.KS_G;
    assign w1 = key_reg[95:64] ^ w0;
    assign w2 = key_reg[63:32] ^ w1;
    assign w3 = key_reg[31:0] ^ w2;
    assign bus.RND_KEY   = {w0, w1, w2, w3};
    assign bus.RND_STATE = state_reg;
    assign bus.RND_FINAL = round == 4'd10;
    assign bus.KS_WORD   = key_reg[31:0];
    assign bus.KS_ROUND  = round;
    assign bus.MEM_ADDR  = mem_addr;
    assign bus.BUSY      = st == LOAD || st == ROUND;
    assign bus.DONE      = st == DONE;
    assign bus.CT        = ct;
    assign bus.HEX       = hex;
    always_comb begin
        st_nxt = st;
        load_addr = bus.MEM_SEL;
        case (st)
            IDLE:  st_nxt = bus.START ? LOAD : IDLE;
            LOAD:  st_nxt = ROUND;
            ROUND: st_nxt = (round == 4'd10) ? DONE : ROUND;
            DONE: begin
`ifdef AES_ROUND_CTRL_START_QUEUE_EN
                st_nxt = (pend || bus.START) ? LOAD : IDLE;
                load_addr = pend ? pend_addr : bus.MEM_SEL;
`else
                st_nxt = IDLE;
`endif
            end
            default: st_nxt = IDLE;
        endcase
    end
    // round returns to 0 on completion so RND_FINAL is confined to the last round
    always_ff @(posedge CLK) begin
        if (!RST) begin
            st <= IDLE;
            state_reg <= '0;
            key_reg <= '0;
            round <= '0;
            mem_addr <= '0;
            ct <= '0;
            hex <= '0;
        end else begin
            st <= st_nxt;
            hex <= ct[{bus.OUT_SEL, 5'd0} +: 32];
            if (st_nxt == LOAD) begin
                mem_addr <= load_addr;
                round <= 4'd1;
            end
            if (st == LOAD) begin
                state_reg <= bus.MEM_DATA ^ bus.KEY;
                key_reg <= bus.KEY;
                round <= 4'd1;
            end
            if (st == ROUND) begin
                state_reg <= bus.RND_RESULT;
                key_reg <= bus.RND_KEY;
                round <= (round == 4'd10) ? 4'd0 : round + 4'd1;
                if (round == 4'd10) ct <= bus.RND_RESULT;
            end
        end
    end
`ifdef AES_ROUND_CTRL_START_QUEUE_EN
    always_ff @(posedge CLK) begin
        if (!RST) begin
            pend <= 1'b0;
            pend_addr <= '0;
        end else if (st == DONE) begin
            pend <= 1'b0;
        end else if (st != IDLE && bus.START && !pend) begin
            pend <= 1'b1;
            pend_addr <= bus.MEM_SEL;
        end
    end
`endif
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: drives aes_round_ctrl with a behavioural AES round/key-schedule and memory,
// comparing ciphertexts and sequencing against a full AES-128 reference.
module tb_aes_round_ctrl;
    logic CLK, RST;
    int checks = 0, failures = 0;
    logic [127:0] mem [16];
    aes_round_ctrl_if bus();
    aes_round_ctrl dut (.CLK(CLK), .RST(RST), .bus(bus));

`ifdef AES_ROUND_CTRL_START_QUEUE_EN
    localparam int Q_DONES = 2, Q_SAW7 = 1, Q_SEL = 7, H_N = 4, H_D2 = 24, H_D3 = 36;
`else
    localparam int Q_DONES = 1, Q_SAW7 = 0, Q_SEL = 2, H_N = 3, H_D2 = 25, H_D3 = 38;
`endif

    initial CLK = 0;
    always #5 CLK = ~CLK;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse (x^254) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r = 8'h01, e = 8'hFE;
        for (int i = 7; i >= 0; i--) begin
            r = gmul(r, r);
            if (e[i]) r = gmul(r, x);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input int n);
        logic [7:0] r = 8'h01;
        for (int i = 1; i < n; i++) r = xt(r);
        return r;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127-32*c -: 32];
            o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                 xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
        return o;
    endfunction

    function automatic logic [127:0] ref_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [127:0] s;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rcon(i/4), 24'h0};
            w[i] = w[i-4] ^ t;
        end
        s = pt ^ {w[0], w[1], w[2], w[3]};
        for (int r = 1; r <= 10; r++) begin
            s = shift_rows(sub_bytes(s));
            if (r < 10) s = mix_columns(s);
            s ^= {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
        return s;
    endfunction

    assign bus.MEM_DATA   = mem[bus.MEM_ADDR];
    assign bus.KS_G       = sub_word({bus.KS_WORD[23:0], bus.KS_WORD[31:24]}) ^ {rcon(int'(bus.KS_ROUND)), 24'h0};
    assign bus.RND_RESULT = (bus.RND_FINAL ? shift_rows(sub_bytes(bus.RND_STATE))
                                           : mix_columns(shift_rows(sub_bytes(bus.RND_STATE)))) ^ bus.RND_KEY;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // one START pulse; KEY and MEM_SEL are scrambled once the key has been captured
    task automatic run_op(input logic [3:0] sel, input logic [127:0] key, input logic [127:0] exp_ct);
        int edges = 1, busy_n = 0, fin_n = 0, fin_at = 0, ks_bad = 0;
        bus.START = 1;
        bus.MEM_SEL = sel;
        bus.KEY = key;
        step();
        bus.START = 0;
        check("load_addr", bus.MEM_ADDR, sel);
        while (edges < 40) begin
            if (bus.BUSY) begin
                busy_n++;
                if (busy_n > 1 && int'(bus.KS_ROUND) != busy_n - 1) ks_bad++;
            end
            if (bus.RND_FINAL) begin
                fin_n++;
                fin_at = busy_n;
            end
            if (bus.DONE) break;
            if (edges == 2) begin
                bus.KEY = {$urandom, $urandom, $urandom, $urandom};
                bus.MEM_SEL = 4'($urandom);
            end
            step();
            edges++;
        end
        check("latency", edges, 12);
        check("busy_cycles", busy_n, 11);
        check("final_count", fin_n, 1);
        check("final_pos", fin_at, 11);
        check("ks_round_seq", ks_bad, 0);
        check("busy_at_done", bus.BUSY, 0);
        check("ct", bus.CT, exp_ct);
        step();
        check("done_one_cycle", bus.DONE, 0);
    endtask

    task automatic sweep(input logic [127:0] c);
        for (int i = 0; i < 4; i++) begin
            bus.OUT_SEL = 2'(i);
            step();
            check("hex", bus.HEX, c[32*i +: 32]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] k, c;
        logic [3:0] s;
        int dones, saw7, pulsed;
        int dpos [$];
        RST = 0;
        bus.START = 0;
        bus.MEM_SEL = 0;
        bus.KEY = 0;
        bus.OUT_SEL = 0;
        for (int i = 0; i < 16; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
        mem[3] = 128'h54776F204F6E65204E696E652054776F;
        mem[5] = 128'h00112233445566778899AABBCCDDEEFF;
        step();
        bus.START = 1;
        bus.MEM_SEL = 4'd9;
        step();
        check("rst_busy", bus.BUSY, 0);
        check("rst_done", bus.DONE, 0);
        check("rst_ct", bus.CT, 0);
        check("rst_hex", bus.HEX, 0);
        check("rst_addr", bus.MEM_ADDR, 0);
        check("rst_round", bus.KS_ROUND, 0);
        check("rst_state", bus.RND_STATE, 0);
        check("rst_ksword", bus.KS_WORD, 0);
        bus.START = 0;
        RST = 1;
        step();
        check("start_in_reset_ignored", bus.BUSY, 0);

        run_op(4'd3, 128'h5468617473206D79204B756E67204675, 128'h29C3505F571420F6402299B31A02D73A);
        run_op(4'd5, 128'h000102030405060708090A0B0C0D0E0F, 128'h69C4E0D86A7B0430D8CDB78070B4C55A);
        sweep(128'h69C4E0D86A7B0430D8CDB78070B4C55A);

        for (int n = 0; n < 4; n++) begin
            s = 4'($urandom);
            k = {$urandom, $urandom, $urandom, $urandom};
            c = ref_enc(mem[s], k);
            run_op(s, k, c);
            sweep(c);
        end

        // abort in round 5 right after a reset, so CT must still read 0
        RST = 0;
        step();
        RST = 1;
        bus.START = 1;
        bus.MEM_SEL = 4'd1;
        step();
        bus.START = 0;
        for (int e = 0; e < 20 && bus.KS_ROUND != 4'd5; e++) step();
        check("abort_at_round5", bus.KS_ROUND, 5);
        RST = 0;
        step();
        RST = 1;
        check("abort_busy", bus.BUSY, 0);
        check("abort_ct", bus.CT, 0);
        dones = 0;
        for (int e = 0; e < 15; e++) begin
            if (bus.DONE) dones++;
            step();
        end
        check("abort_no_done", dones, 0);
        k = {$urandom, $urandom, $urandom, $urandom};
        run_op(4'd6, k, ref_enc(mem[6], k));

        // second START in round 3
        k = {$urandom, $urandom, $urandom, $urandom};
        bus.KEY = k;
        bus.MEM_SEL = 4'd2;
        bus.START = 1;
        step();
        dones = 0;
        saw7 = 0;
        pulsed = 0;
        c = 0;
        for (int e = 0; e < 50; e++) begin
            bus.START = 0;
            if (bus.DONE) begin
                dones++;
                c = bus.CT;
            end
            if (dones > 0 && bus.BUSY && bus.MEM_ADDR == 4'd7) saw7 = 1;
            if (pulsed == 0 && bus.BUSY && bus.KS_ROUND == 4'd3) begin
                bus.START = 1;
                bus.MEM_SEL = 4'd7;
                pulsed = 1;
            end
            step();
        end
        bus.START = 0;
        check("queue_dones", dones, Q_DONES);
        check("queue_addr7", saw7, Q_SAW7);
        check("queue_last_ct", c, ref_enc(mem[Q_SEL], k));

        // START held for 30 edges
        bus.START = 1;
        for (int e = 1; e <= 60; e++) begin
            step();
            if (e == 30) bus.START = 0;
            if (bus.DONE) dpos.push_back(e);
        end
        check("held_done_count", dpos.size(), H_N);
        while (dpos.size() < 4) dpos.push_back(0);
        check("held_done_1", dpos[0], 12);
        check("held_done_2", dpos[1], H_D2);
        check("held_done_3", dpos[2], H_D3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
